// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//   Shares the register file's single write port among N_REQ writeback
//   requesters with round-robin arbitration. It also keeps a busy scoreboard
//   of reserved destination registers and flags read-after-write hazards for
//   the two register-file read ports.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/addr/data   per-requester write requests (packed, slice i)
//   req_ready             one-hot grant, combinational
//   rsv_valid/rsv_addr    destination reservation from issue
//   rsv_stall             reservation refused (register already busy)
//   rd_addr_1/2           register-file read addresses
//   hazard_1/2            read value not yet valid in the register file
//   busy_mask             scoreboard, bit 0 always 0
//   reg_write/write_reg/write_data  registered register-file write port
//
// Notes
//   The scoreboard is 32 entries wide, so ADDR_W is expected to be 5.
//   If a reservation and a write target the same idle register at the same
//   edge, the reservation wins: it belongs to a later producer.

module reg_wb_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_stall,
  input  logic [ADDR_W-1:0]        rd_addr_1,
  input  logic [ADDR_W-1:0]        rd_addr_2,
  output logic                     hazard_1,
  output logic                     hazard_2,
  output logic [31:0]              busy_mask,
  output logic                     reg_write,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data
);

  localparam int unsigned PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NUM_REGS = 32;

  // (base + off) mod N_REQ for base, off < N_REQ
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    return PTR_W'(sum);
  endfunction

  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    scan_idx;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_next;

  // Round-robin scan: first valid requester at or after the pointer
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = wrap_add(ptr_q, k);
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // One-hot grant; only ever raised on a valid requester
  always_comb begin
    req_ready = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Payload of the granted requester
  always_comb begin
    sel_addr = req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
    sel_data = req_data[32'(grant_idx)*DATA_W +: DATA_W];
  end

  // Pointer moves past the winner; holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_any) begin
      ptr_q <= wrap_add(grant_idx, 1);
    end
  end

  // Registered write port; register 0 completes the handshake silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      reg_write <= grant_any && (sel_addr != '0);
      if (grant_any) begin
        write_reg  <= sel_addr;
        write_data <= sel_data;
      end
    end
  end

  // Reservation refused while the destination still has a write outstanding
  always_comb begin
    rsv_stall = rsv_valid && busy_q[rsv_addr];
  end

  // Scoreboard next state: clear on transfer, then set on accepted reservation
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (rsv_valid && !rsv_stall && (rsv_addr != '0)) begin
      set_vec[rsv_addr] = 1'b1;
    end
    if (grant_any) begin
      clr_vec[sel_addr] = 1'b1;
    end
    busy_next    = (busy_q & ~clr_vec) | set_vec;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  always_comb begin
    busy_mask = busy_q;
  end

  // Hazard covers both reserved registers and the write currently landing
  always_comb begin
    hazard_1 = (rd_addr_1 != '0) &&
               (busy_q[rd_addr_1] || (reg_write && (write_reg == rd_addr_1)));
    hazard_2 = (rd_addr_2 != '0) &&
               (busy_q[rd_addr_2] || (reg_write && (write_reg == rd_addr_2)));
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_stall;
  logic [AW-1:0]   rd_addr_1;
  logic [AW-1:0]   rd_addr_2;
  logic            hazard_1;
  logic            hazard_2;
  logic [31:0]     busy_mask;
  logic            reg_write;
  logic [AW-1:0]   write_reg;
  logic [DW-1:0]   write_data;

  int total = 0;
  int bad   = 0;

  reg_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_stall(rsv_stall),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .hazard_1(hazard_1), .hazard_2(hazard_2),
    .busy_mask(busy_mask),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy[32];
  int          m_ptr;
  bit          m_rw;
  int          m_wreg;
  logic [31:0] m_wdata;

  int           g;
  logic [N-1:0] ev;
  bit           e_stall;
  bit           e_h1;
  bit           e_h2;
  logic [31:0]  e_mask;
  int           ga;
  logic [31:0]  gd;

  always @(negedge clk) begin
    #3;
    if (rst) begin
      foreach (m_busy[r]) m_busy[r] = 0;
      m_ptr = 0; m_rw = 0; m_wreg = 0; m_wdata = '0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
      ev = '0;
      if (g >= 0) ev[g] = 1'b1;
      e_stall = rsv_valid && m_busy[rsv_addr];
      e_h1 = (rd_addr_1 != 0) && (m_busy[rd_addr_1] || (m_rw && m_wreg == int'(rd_addr_1)));
      e_h2 = (rd_addr_2 != 0) && (m_busy[rd_addr_2] || (m_rw && m_wreg == int'(rd_addr_2)));
      e_mask = '0;
      for (int r = 0; r < 32; r++) e_mask[r] = m_busy[r];

      chk("req_ready", 64'(req_ready), 64'(ev));
      chk("rsv_stall", 64'(rsv_stall), 64'(e_stall));
      chk("hazard_1", 64'(hazard_1), 64'(e_h1));
      chk("hazard_2", 64'(hazard_2), 64'(e_h2));
      chk("busy_mask", 64'(busy_mask), 64'(e_mask));
      chk("reg_write", 64'(reg_write), 64'(m_rw));
      chk("write_reg", 64'(write_reg), 64'(m_wreg));
      chk("write_data", 64'(write_data), 64'(m_wdata));

      // advance the model across the coming edge
      if (g >= 0) begin
        ga = int'(req_addr[g*AW +: AW]);
        gd = req_data[g*DW +: DW];
        m_rw = (ga != 0);
        m_wreg = ga;
        m_wdata = gd;
        m_busy[ga] = 0;
        m_ptr = (g + 1) % N;
      end else begin
        m_rw = 0;
      end
      if (rsv_valid && !e_stall && rsv_addr != 0) m_busy[rsv_addr] = 1;
      m_busy[0] = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cyc();
    @(negedge clk);
    req_valid = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
  endtask

  task automatic set_req(input int i, input int a, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic reserve(input int a);
    rsv_valid = 1'b1;
    rsv_addr  = AW'(a);
  endtask

  int          cnt[N];
  int          last_addr;
  logic [N-1:0] exp_ready;
  bit          pend[N];
  int          paddr[N];
  logic [31:0] pdata[N];
  bit          xfer[N];

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    rd_addr_1 = 5'd3; rd_addr_2 = '0;
    repeat (2) @(negedge clk);
    #4;
    chk("reset busy_mask", 64'(busy_mask), 64'h0);
    chk("reset reg_write", 64'(reg_write), 64'h0);
    chk("reset req_ready", 64'(req_ready), 64'h0);
    chk("reset hazard_1", 64'(hazard_1), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // single write through requester 1
    next_cyc(); reserve(5); rd_addr_1 = 5'd5;
    #4 chk("sw hazard same cycle", 64'(hazard_1), 64'h0);
    next_cyc(); set_req(1, 5, 32'hDEAD_BEEF);
    #4 chk("sw ready", 64'(req_ready), 64'b010);
    chk("sw hazard reserved", 64'(hazard_1), 64'h1);
    chk("sw busy set", 64'(busy_mask), 64'h20);
    next_cyc();
    #4 chk("sw reg_write", 64'(reg_write), 64'h1);
    chk("sw write_reg", 64'(write_reg), 64'h5);
    chk("sw write_data", 64'(write_data), 64'hDEAD_BEEF);
    chk("sw busy clear", 64'(busy_mask), 64'h0);
    chk("sw hazard writing", 64'(hazard_1), 64'h1);
    next_cyc();
    #4 chk("sw hazard gone", 64'(hazard_1), 64'h0);
    chk("sw reg_write low", 64'(reg_write), 64'h0);

    // asynchronous reset while busy and writing
    for (int r = 8; r <= 12; r++) begin
      next_cyc(); reserve(r);
    end
    next_cyc(); set_req(0, 12, 32'hCAFE_0012);
    next_cyc(); rd_addr_1 = 5'd8;
    #4 chk("pre-rst reg_write", 64'(reg_write), 64'h1);
    chk("pre-rst busy", 64'(busy_mask), 64'h0000_0F00);
    chk("pre-rst hazard", 64'(hazard_1), 64'h1);
    #1 rst = 1'b1;
    #1 chk("async rst busy", 64'(busy_mask), 64'h0);
    chk("async rst reg_write", 64'(reg_write), 64'h0);
    chk("async rst write_reg", 64'(write_reg), 64'h0);
    chk("async rst ready", 64'(req_ready), 64'h0);
    chk("async rst hazard", 64'(hazard_1), 64'h0);
    next_cyc();
    next_cyc(); rst = 1'b0;

    // round-robin with all requesters always valid
    foreach (cnt[i]) cnt[i] = 0;
    last_addr = 0;
    for (int c = 0; c < 7; c++) begin
      next_cyc();
      if (c < 6) for (int i = 0; i < N; i++) set_req(i, 16 + i*4 + cnt[i], 32'(c*16 + i));
      #4;
      if (c < 6) begin
        exp_ready = 3'b001 << (c % 3);
        chk("rr grant", 64'(req_ready), 64'(exp_ready));
      end
      if (c > 0) begin
        chk("rr reg_write", 64'(reg_write), 64'h1);
        chk("rr write_reg", 64'(write_reg), 64'(last_addr));
      end
      if (c < 6) begin
        last_addr = 16 + (c % 3)*4 + cnt[c % 3];
        cnt[c % 3]++;
      end
    end

    // register 0
    next_cyc(); set_req(2, 0, 32'h1234); reserve(0);
    #4 chk("r0 ready", 64'(req_ready), 64'b100);
    chk("r0 stall", 64'(rsv_stall), 64'h0);
    next_cyc(); set_req(1, 20, 32'h20); set_req(2, 21, 32'h21);
    #4 chk("r0 reg_write", 64'(reg_write), 64'h0);
    chk("r0 busy", 64'(busy_mask), 64'h0);
    chk("r0 pointer", 64'(req_ready), 64'b010);
    next_cyc(); set_req(2, 21, 32'h21);
    #4 chk("r0 next grant", 64'(req_ready), 64'b100);

    // WAW stall and concurrent set/clear
    next_cyc(); reserve(7);
    #4 chk("waw first", 64'(rsv_stall), 64'h0);
    next_cyc(); reserve(7);
    #4 chk("waw stall", 64'(rsv_stall), 64'h1);
    next_cyc(); reserve(9);
    #4 chk("waw busy unchanged", 64'(busy_mask), 64'h80);
    next_cyc(); set_req(0, 9, 32'h99); reserve(3);
    #4 chk("cc grant", 64'(req_ready), 64'b001);
    chk("cc busy before", 64'(busy_mask), 64'h280);
    next_cyc(); set_req(1, 7, 32'h77);
    #4 chk("cc busy after", 64'(busy_mask), 64'h88);
    next_cyc(); reserve(7);
    #4 chk("waw retry", 64'(rsv_stall), 64'h0);
    chk("waw cleared", 64'(busy_mask), 64'h08);
    next_cyc();
    #4 chk("waw reserved", 64'(busy_mask), 64'h88);

    // randomized traffic, requesters obey the handshake
    foreach (pend[i]) begin pend[i] = 0; xfer[i] = 0; end
    for (int c = 0; c < 2000; c++) begin
      next_cyc();
      for (int i = 0; i < N; i++) begin
        if (xfer[i]) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1;
          paddr[i] = int'($urandom_range(0, 15));
          pdata[i] = $urandom;
        end
        if (pend[i]) set_req(i, paddr[i], pdata[i]);
      end
      if ($urandom_range(0, 1) == 1) reserve(int'($urandom_range(0, 15)));
      rd_addr_1 = AW'($urandom_range(0, 15));
      rd_addr_2 = AW'($urandom_range(0, 15));
      #4;
      for (int i = 0; i < N; i++) xfer[i] = req_valid[i] && req_ready[i];
    end

    next_cyc();
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
